usb_audio_gain: RTL and testbench

- Downstream of the USB audio interface block; consumes its 48 kHz stereo samples and its Volume/Mute controls.
- Applies a per-channel volume with a de-zippered gain ramp, a soft mute, and a serial shift-add multiplier.
- Delivers gain-scaled 16-bit samples to the DAC/I2S stage.
- Runs entirely in the USB Clk domain. Audio_Clk is treated as an asynchronous input and synchronised internally.

---
 rtl/usb_audio_gain.sv | 158 +++++++++++++++
 tb/tb_usb_audio_gain.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/usb_audio_gain.sv
// Per-channel volume stage for 48 kHz stereo audio. Each channel's gain ramps
// toward its target in small steps, with soft mute, and the sample is scaled by a serial shift-add multiplier.
//
// state | meaning
// IDLE  | waiting for a synchronised Audio_Clk rising edge
// LOAD  | capture samples, step the gains toward target, form g9 multipliers
// MUL_L | 9-cycle shift-add, left sample x g9_l
// MUL_R | 9-cycle shift-add, right sample x g9_r
// DONE  | new outputs visible, Out_Valid high for one cycle
module usb_audio_gain #(
    parameter int STEP        = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic        Clk,
    input  logic        nReset,
    input  logic        Audio_Clk,
    input  logic [15:0] Audio_In_Left,
    input  logic [15:0] Audio_In_Right,
    input  logic [7:0]  Volume_Left,
    input  logic [7:0]  Volume_Right,
    input  logic        Mute,
    output logic [15:0] Audio_Out_Left,
    output logic [15:0] Audio_Out_Right,
    output logic        Out_Valid,
    output logic        Busy,
    output logic        Overrun
);

    typedef enum logic [2:0] {IDLE, LOAD, MUL_L, MUL_R, DONE} state_t;

    localparam logic [8:0] STEP9 = 9'(STEP);

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   aclk_prev;
    logic                   rise;

    logic [7:0]  cur_gain_l, cur_gain_r;
    logic [7:0]  gain_l_nxt, gain_r_nxt;
    logic [8:0]  g9_r;
    logic [15:0] samp_r;
    logic [24:0] mcand;
    logic [8:0]  mplier;
    logic [24:0] acc, acc_nxt;
    logic [15:0] res_l;
    logic [3:0]  cnt;
    logic        cnt_tc;

    function automatic logic [7:0] ramp(input logic [7:0] cur, input logic [7:0] tgt);
        logic [8:0] c9, t9;
        c9 = {1'b0, cur};
        t9 = {1'b0, tgt};
        if (t9 >= c9) begin
            if (t9 - c9 <= STEP9) return tgt;
            return 8'(c9 + STEP9);
        end
        if (c9 - t9 <= STEP9) return tgt;
        return 8'(c9 - STEP9);
    endfunction

    // Code 255 maps to 256 so full scale is bit-exact unity; code 0 stays 0.
    function automatic logic [8:0] to_g9(input logic [7:0] g);
        return (g == 8'd0) ? 9'd0 : ({1'b0, g} + 9'd1);
    endfunction

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            sync_q    <= '0;
            aclk_prev <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], Audio_Clk};
            aclk_prev <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise       = sync_q[SYNC_STAGES-1] & ~aclk_prev;
    assign cnt_tc     = (cnt == 4'd0);
    assign gain_l_nxt = ramp(cur_gain_l, Mute ? 8'd0 : Volume_Left);
    assign gain_r_nxt = ramp(cur_gain_r, Mute ? 8'd0 : Volume_Right);
    assign acc_nxt    = mplier[0] ? (acc + mcand) : acc;

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        Busy      = (state != IDLE);
        Out_Valid = (state == DONE);
        Overrun   = rise & (state != IDLE);
        case (state)
            IDLE:    if (rise) state_nxt = LOAD;
            LOAD:    state_nxt = MUL_L;
            MUL_L:   if (cnt_tc) state_nxt = MUL_R;
            MUL_R:   if (cnt_tc) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            cur_gain_l      <= '0;
            cur_gain_r      <= '0;
            g9_r            <= '0;
            samp_r          <= '0;
            mcand           <= '0;
            mplier          <= '0;
            acc             <= '0;
            res_l           <= '0;
            cnt             <= '0;
            Audio_Out_Left  <= '0;
            Audio_Out_Right <= '0;
        end else begin
            case (state)
                LOAD: begin
                    samp_r     <= Audio_In_Right;
                    cur_gain_l <= gain_l_nxt;
                    cur_gain_r <= gain_r_nxt;
                    g9_r       <= to_g9(gain_r_nxt);
                    mcand      <= {{9{Audio_In_Left[15]}}, Audio_In_Left};
                    mplier     <= to_g9(gain_l_nxt);
                    acc        <= '0;
                    cnt        <= 4'd8;
                end
                MUL_L: begin
                    if (cnt_tc) begin
                        res_l  <= acc_nxt[23:8];
                        mcand  <= {{9{samp_r[15]}}, samp_r};
                        mplier <= g9_r;
                        acc    <= '0;
                        cnt    <= 4'd8;
                    end else begin
                        acc    <= acc_nxt;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt - 4'd1;
                    end
                end
                MUL_R: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - 4'd1;
                    // Both outputs change together so they hold steady between Out_Valid pulses.
                    if (cnt_tc) begin
                        Audio_Out_Left  <= res_l;
                        Audio_Out_Right <= acc_nxt[23:8];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_audio_gain.sv
// Directed bench for usb_audio_gain: fade-in, gain points, mute ramp, coarse STEP,
// overrun and mid-sample reset.
module tb_usb_audio_gain;

    logic        Clk = 1'b0;
    logic        nReset;
    logic        aclk, aclk16;
    logic [15:0] in_l, in_r, in16;
    logic [7:0]  vol_l, vol_r, vol16;
    logic        mute, mute16;
    logic [15:0] out_l, out_r, o16_l, o16_r;
    logic        ov, busy, ovr, ov16, busy16, ovr16;

    int total = 0;
    int bad   = 0;
    int ov_cnt = 0;
    int or_cnt = 0;
    int gm_l, gm_r;

    always #5 Clk = ~Clk;

    usb_audio_gain #(.STEP(1), .SYNC_STAGES(2)) dut (
        .Clk(Clk), .nReset(nReset), .Audio_Clk(aclk),
        .Audio_In_Left(in_l), .Audio_In_Right(in_r),
        .Volume_Left(vol_l), .Volume_Right(vol_r), .Mute(mute),
        .Audio_Out_Left(out_l), .Audio_Out_Right(out_r),
        .Out_Valid(ov), .Busy(busy), .Overrun(ovr)
    );

    usb_audio_gain #(.STEP(16), .SYNC_STAGES(2)) dut16 (
        .Clk(Clk), .nReset(nReset), .Audio_Clk(aclk16),
        .Audio_In_Left(in16), .Audio_In_Right(in16),
        .Volume_Left(vol16), .Volume_Right(vol16), .Mute(mute16),
        .Audio_Out_Left(o16_l), .Audio_Out_Right(o16_r),
        .Out_Valid(ov16), .Busy(busy16), .Overrun(ovr16)
    );

    always @(negedge Clk) begin
        if (ov)  ov_cnt++;
        if (ovr) or_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic int ramp_m(input int cur, input int tgt, input int step);
        if (tgt >= cur) return (tgt - cur <= step) ? tgt : cur + step;
        return (cur - tgt <= step) ? tgt : cur - step;
    endfunction

    function automatic logic [15:0] scale(input logic [15:0] s, input int g);
        int g9, p;
        g9 = (g == 0) ? 0 : g + 1;
        p  = int'($signed(s)) * g9;
        return 16'(p >>> 8);
    endfunction

    // Latency is counted from the posedge after Audio_Clk rises: 2 sync flops + 20.
    task automatic drive_edge(input bit sel, output int lat, output logic [15:0] ol, output logic [15:0] orr);
        lat = 0;
        ol  = '0;
        orr = '0;
        @(posedge Clk);
        #1;
        if (sel) aclk16 = 1'b1;
        else     aclk   = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge Clk);
            @(negedge Clk);
            if (sel ? ov16 : ov) begin
                lat = n;
                ol  = sel ? o16_l : out_l;
                orr = sel ? o16_r : out_r;
                break;
            end
        end
        @(posedge Clk);
        #1;
        aclk   = 1'b0;
        aclk16 = 1'b0;
        repeat (17) @(posedge Clk);
    endtask

    task automatic main_sample(input logic [15:0] l, input logic [15:0] r,
                               output logic [15:0] ol, output logic [15:0] orr);
        int lat;
        in_l = l;
        in_r = r;
        repeat (2) @(posedge Clk);
        gm_l = ramp_m(gm_l, mute ? 0 : int'(vol_l), 1);
        gm_r = ramp_m(gm_r, mute ? 0 : int'(vol_r), 1);
        drive_edge(1'b0, lat, ol, orr);
        check("latency", lat, 22);
        check("out_l", ol, scale(l, gm_l));
        check("out_r", orr, scale(r, gm_r));
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] ol, orr, prev;
        logic [15:0] exp16 [4];
        int lat, ov0, or0, n;

        nReset = 1'b0;
        aclk = 1'b0; aclk16 = 1'b0;
        in_l = '0; in_r = '0; in16 = '0;
        vol_l = 8'd255; vol_r = 8'd255; mute = 1'b0;
        vol16 = 8'd0; mute16 = 1'b0;
        gm_l = 0; gm_r = 0;
        repeat (3) @(posedge Clk);
        #1;
        check("rst_out_l", out_l, 16'h0);
        check("rst_out_r", out_r, 16'h0);
        check("rst_valid", ov, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_overrun", ovr, 1'b0);
        nReset = 1'b1;

        // fade-in from gain 0 to unity
        for (int i = 1; i <= 300; i++) begin
            main_sample(16'h1234, 16'h8000, ol, orr);
            if (i == 255) begin
                check("unity_l_255", ol, 16'h1234);
                check("unity_r_255", orr, 16'h8000);
            end
        end
        check("unity_l_end", ol, 16'h1234);
        check("unity_r_end", orr, 16'h8000);

        // ramp down to 128, then gain points
        vol_l = 8'd128; vol_r = 8'd128;
        repeat (127) main_sample(16'h4000, 16'hFFFF, ol, orr);
        main_sample(16'h4000, 16'hFFFF, ol, orr);
        check("g128_4000", ol, 16'h2040);
        check("g128_ffff", orr, 16'hFFFF);
        main_sample(16'h0001, 16'h0001, ol, orr);
        check("g128_0001_l", ol, 16'h0000);
        check("g128_0001_r", orr, 16'h0000);

        // back to full scale, then soft mute and release
        vol_l = 8'd255; vol_r = 8'd255;
        repeat (127) main_sample(16'h7FFF, 16'h7FFF, ol, orr);
        check("full_7fff", ol, 16'h7FFF);
        mute = 1'b1;
        prev = ol;
        for (int k = 1; k <= 255; k++) begin
            main_sample(16'h7FFF, 16'h7FFF, ol, orr);
            check("mute_dec", ol < prev, 1'b1);
            prev = ol;
        end
        check("mute_zero_l", ol, 16'h0);
        check("mute_zero_r", orr, 16'h0);
        mute = 1'b0;
        repeat (255) main_sample(16'h7FFF, 16'h7FFF, ol, orr);
        check("unmute_l", ol, 16'h7FFF);
        check("unmute_r", orr, 16'h7FFF);

        // STEP=16 instance: gain 0 -> 40 goes 16, 32, 40, 40
        exp16[0] = 16'h0110; exp16[1] = 16'h0210; exp16[2] = 16'h0290; exp16[3] = 16'h0290;
        vol16 = 8'd40;
        in16  = 16'h1000;
        for (int i = 0; i < 4; i++) begin
            repeat (2) @(posedge Clk);
            drive_edge(1'b1, lat, ol, orr);
            check("s16_latency", lat, 22);
            check("s16_out_l", ol, exp16[i]);
            check("s16_out_r", orr, exp16[i]);
        end

        // two Audio_Clk rises 10 Clk apart: second is dropped with Overrun
        in_l = 16'h0ABC; in_r = 16'hF00D;
        repeat (2) @(posedge Clk);
        gm_l = ramp_m(gm_l, int'(vol_l), 1);
        gm_r = ramp_m(gm_r, int'(vol_r), 1);
        ov0 = ov_cnt; or0 = or_cnt;
        @(posedge Clk); #1 aclk = 1'b1;
        repeat (5) @(posedge Clk); #1 aclk = 1'b0;
        repeat (5) @(posedge Clk); #1 aclk = 1'b1;
        n = 10; lat = 0;
        while (n < 60) begin
            @(posedge Clk);
            n++;
            @(negedge Clk);
            if (ov) begin
                lat = n;
                break;
            end
        end
        ol = out_l; orr = out_r;
        check("ovr_latency", lat, 22);
        check("ovr_out_l", ol, scale(16'h0ABC, gm_l));
        check("ovr_out_r", orr, scale(16'hF00D, gm_r));
        @(posedge Clk); #1 aclk = 1'b0;
        repeat (30) @(posedge Clk);
        check("ovr_valid_count", ov_cnt - ov0, 1);
        check("ovr_pulse_count", or_cnt - or0, 1);

        // reset during MUL_R (E+12)
        in_l = 16'h1111; in_r = 16'h2222;
        repeat (2) @(posedge Clk);
        ov0 = ov_cnt;
        @(posedge Clk); #1 aclk = 1'b1;
        repeat (14) @(posedge Clk);
        #1;
        check("pre_rst_busy", busy, 1'b1);
        nReset = 1'b0;
        aclk   = 1'b0;
        #1;
        check("midrst_out_l", out_l, 16'h0);
        check("midrst_out_r", out_r, 16'h0);
        check("midrst_valid", ov, 1'b0);
        check("midrst_busy", busy, 1'b0);
        repeat (3) @(posedge Clk);
        #1 nReset = 1'b1;
        gm_l = 0; gm_r = 0;
        repeat (30) @(posedge Clk);
        check("midrst_no_valid", ov_cnt - ov0, 0);
        main_sample(16'h0040, 16'h007F, ol, orr);
        check("post_rst_l", ol, 16'h0000);
        check("post_rst_r", orr, 16'h0000);
        main_sample(16'h4000, 16'h4000, ol, orr);
        check("post_rst_g2", ol, 16'h00C0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
